// File: rtl/sprite_span_sched_pkg.sv
// Shared video definitions for the sprite span scheduler: image geometry,
// the transparent key color, FSM states and the pixel tag record.
package sprite_span_sched_pkg;

  localparam int VID_COLOR_W = 12;
  localparam int VID_IMG_W   = 584;
  localparam logic [VID_COLOR_W-1:0] VID_TRANSPARENT = 12'hFFF;

  // Tag fields are sized for the largest supported configuration
  // (8 requesters, 10-bit columns); the top narrows them on output.
  localparam int TAG_ID_W  = 3;
  localparam int TAG_COL_W = 10;

  typedef enum logic {
    S_IDLE  = 1'b0,
    S_BURST = 1'b1
  } state_t;

  // Travels alongside the ROM read so each returned color knows its owner.
  typedef struct packed {
    logic                 valid;
    logic                 null_span;
    logic [TAG_ID_W-1:0]  id;
    logic [TAG_COL_W-1:0] col;
    logic                 last;
  } span_tag_t;

endpackage

// File: rtl/sprite_span_sched_rr_pick.sv
// Combinational round-robin picker: first set request at or after ptr,
// wrapping around, returned as one-hot grant plus binary index.
module sprite_span_sched_rr_pick #(
  parameter int N_REQ = 4,
  parameter int ID_W  = 2
) (
  input  logic [N_REQ-1:0] req,
  input  logic [ID_W-1:0]  ptr,
  output logic [N_REQ-1:0] grant,
  output logic [ID_W-1:0]  idx,
  output logic             any
);

  int j;

  // Scan from ptr upward with wrap; the first hit wins.
  always_comb begin
    grant = '0;
    idx   = '0;
    any   = 1'b0;
    j     = 0;
    for (int off = 0; off < N_REQ; off++) begin
      j = (int'(ptr) + off) % N_REQ;
      if (!any && req[j]) begin
        any      = 1'b1;
        grant[j] = 1'b1;
        idx      = ID_W'(j);
      end
    end
  end

endmodule

// File: rtl/sprite_span_sched.sv
// Shares one registered sprite ROM among N_REQ renderers. Whole spans are
// granted round-robin, the ROM address walks one pixel per clock, and each
// returned color is tagged with owner, column and end-of-span.
//
// Request handshake: a requester raises span_req[i] with its row/col/len
// stable and holds them until span_ack[i] pulses for one cycle; the span is
// captured on that edge. Dropping span_req before the ack withdraws it.
// The pixel stream has no back-pressure: a requester must accept every
// pix_valid cycle carrying its id.
module sprite_span_sched
  import sprite_span_sched_pkg::*;
#(
  parameter int N_REQ   = 4,
  parameter int ROW_W   = 8,
  parameter int COL_W   = 10,
  parameter int COLOR_W = VID_COLOR_W,
  parameter int IMG_W   = VID_IMG_W,
  parameter int ROM_LAT = 1,
  parameter logic [COLOR_W-1:0] TRANSPARENT = VID_TRANSPARENT,
  parameter int ID_W    = $clog2(N_REQ)
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [N_REQ-1:0]       span_req,
  input  logic [N_REQ*ROW_W-1:0] span_row,
  input  logic [N_REQ*COL_W-1:0] span_col,
  input  logic [N_REQ*COL_W-1:0] span_len,
  output logic [N_REQ-1:0]       span_ack,
  output logic [ROW_W-1:0]       rom_row,
  output logic [COL_W-1:0]       rom_col,
  input  logic [COLOR_W-1:0]     rom_color,
  output logic                   pix_valid,
  output logic [ID_W-1:0]        pix_id,
  output logic [COL_W-1:0]       pix_col,
  output logic [COLOR_W-1:0]     pix_color,
  output logic                   pix_opaque,
  output logic                   pix_last,
  output logic                   busy,
  output logic                   dbg_state
);

  localparam logic [COL_W:0] IMG_END = (COL_W+1)'(IMG_W);

  state_t           state, state_n;
  logic [ID_W-1:0]  ptr, id_q, pick_idx;
  logic [N_REQ-1:0] pick_grant;
  logic             pick_any;
  logic             null_q;
  logic [COL_W:0]   end_q;

  logic [ROW_W-1:0] sel_row;
  logic [COL_W-1:0] sel_col, sel_len;
  logic [COL_W:0]   sel_sum, sel_end;
  logic             sel_null;
  logic             grant_now, last_c, pipe_busy;

  span_tag_t push_tag, tag_out;
  span_tag_t tag_pipe [ROM_LAT];

  sprite_span_sched_rr_pick #(.N_REQ(N_REQ), .ID_W(ID_W)) u_pick (
    .req   (span_req),
    .ptr   (ptr),
    .grant (pick_grant),
    .idx   (pick_idx),
    .any   (pick_any)
  );

  assign grant_now = (state == S_IDLE) && pick_any;
  assign dbg_state = state;

  // Fetch the winner's span and clip its end to the image edge.
  always_comb begin
    sel_row  = span_row[pick_idx*ROW_W +: ROW_W];
    sel_col  = span_col[pick_idx*COL_W +: COL_W];
    sel_len  = span_len[pick_idx*COL_W +: COL_W];
    sel_sum  = {1'b0, sel_col} + {1'b0, sel_len};
    sel_end  = (sel_sum > IMG_END) ? IMG_END : sel_sum;
    sel_null = ({1'b0, sel_col} >= IMG_END) || (sel_len == '0);
  end

  // Next state and the tag pushed alongside each ROM address.
  always_comb begin
    state_n  = state;
    push_tag = '0;
    last_c   = null_q || (({1'b0, rom_col} + (COL_W+1)'(1)) == end_q);
    case (state)
      S_IDLE: begin
        if (pick_any) state_n = S_BURST;
      end
      S_BURST: begin
        push_tag.valid     = 1'b1;
        push_tag.null_span = null_q;
        push_tag.id        = TAG_ID_W'(id_q);
        push_tag.col       = null_q ? '0 : TAG_COL_W'(rom_col);
        push_tag.last      = last_c;
        if (last_c) state_n = S_IDLE;
      end
      default: state_n = S_IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_n;
  end

  // Grant capture, round-robin pointer and ROM address walk.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ptr      <= '0;
      id_q     <= '0;
      null_q   <= 1'b0;
      end_q    <= '0;
      span_ack <= '0;
      rom_row  <= '0;
      rom_col  <= '0;
    end else begin
      span_ack <= grant_now ? pick_grant : '0;
      if (grant_now) begin
        id_q   <= pick_idx;
        null_q <= sel_null;
        end_q  <= sel_end;
        ptr    <= (pick_idx == ID_W'(N_REQ-1)) ? '0 : pick_idx + ID_W'(1);
        // A null span leaves the ROM address untouched.
        if (!sel_null) begin
          rom_row <= sel_row;
          rom_col <= sel_col;
        end
      end else if ((state == S_BURST) && !last_c) begin
        rom_col <= rom_col + COL_W'(1);
      end
    end
  end

  // Tag delay line matching the ROM read latency.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < ROM_LAT; i++) tag_pipe[i] <= '0;
    end else begin
      for (int i = ROM_LAT-1; i > 0; i--) tag_pipe[i] <= tag_pipe[i-1];
      tag_pipe[0] <= push_tag;
    end
  end

  assign tag_out = tag_pipe[ROM_LAT-1];

  // Any tag still travelling toward the output keeps busy high.
  always_comb begin
    pipe_busy = 1'b0;
    for (int i = 0; i < ROM_LAT; i++) pipe_busy = pipe_busy | tag_pipe[i].valid;
  end

  // Output register joining the ROM data with its tag.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pix_valid  <= 1'b0;
      pix_id     <= '0;
      pix_col    <= '0;
      pix_color  <= '0;
      pix_opaque <= 1'b0;
      pix_last   <= 1'b0;
    end else begin
      pix_valid  <= tag_out.valid;
      pix_id     <= ID_W'(tag_out.id);
      pix_col    <= COL_W'(tag_out.col);
      pix_color  <= (tag_out.valid && !tag_out.null_span) ? rom_color : '0;
      pix_opaque <= tag_out.valid && !tag_out.null_span && (rom_color != TRANSPARENT);
      pix_last   <= tag_out.valid && tag_out.last;
    end
  end

  assign busy = (state != S_IDLE) || pipe_busy || pix_valid;

endmodule

// File: tb/tb_sprite_span_sched.sv
// Directed bench for sprite_span_sched with a registered ROM model.
module tb_sprite_span_sched;

  localparam int N_REQ = 4;
  localparam int ROW_W = 8;
  localparam int COL_W = 10;
  localparam int COLOR_W = 12;
  localparam int ID_W = 2;

  logic                   clk = 1'b0;
  logic                   rst_n = 1'b0;
  logic [N_REQ-1:0]       span_req = '0;
  logic [N_REQ*ROW_W-1:0] span_row = '0;
  logic [N_REQ*COL_W-1:0] span_col = '0;
  logic [N_REQ*COL_W-1:0] span_len = '0;
  logic [N_REQ-1:0]       span_ack;
  logic [ROW_W-1:0]       rom_row;
  logic [COL_W-1:0]       rom_col;
  logic [COLOR_W-1:0]     rom_color = '0;
  logic                   pix_valid;
  logic [ID_W-1:0]        pix_id;
  logic [COL_W-1:0]       pix_col;
  logic [COLOR_W-1:0]     pix_color;
  logic                   pix_opaque;
  logic                   pix_last;
  logic                   busy;
  logic                   dbg_state;

  int compared = 0;
  int mismatched = 0;
  int rom_mode = 0;

  sprite_span_sched dut (
    .clk(clk), .rst_n(rst_n),
    .span_req(span_req), .span_row(span_row), .span_col(span_col), .span_len(span_len),
    .span_ack(span_ack), .rom_row(rom_row), .rom_col(rom_col), .rom_color(rom_color),
    .pix_valid(pix_valid), .pix_id(pix_id), .pix_col(pix_col), .pix_color(pix_color),
    .pix_opaque(pix_opaque), .pix_last(pix_last), .busy(busy), .dbg_state(dbg_state)
  );

  // Clock / reset
  always #5 clk = ~clk;

  // Mode 0: color encodes row/col; mode 1: transparent except cols 10..12.
  function automatic logic [11:0] rom_model(input logic [7:0] r, input logic [9:0] c);
    if (rom_mode == 1) return (c >= 10 && c <= 12) ? 12'hF23 : 12'hFFF;
    return {r[3:0], c[7:0]};
  endfunction

  always @(posedge clk) rom_color <= rom_model(rom_row, rom_col);

  // Driver tasks
  task automatic set_req(input int i, input int row, input int col, input int len);
    span_row[i*ROW_W +: ROW_W] = ROW_W'(row);
    span_col[i*COL_W +: COL_W] = COL_W'(col);
    span_len[i*COL_W +: COL_W] = COL_W'(len);
    span_req[i] = 1'b1;
  endtask

  task automatic drop_acked();
    for (int i = 0; i < N_REQ; i++) if (span_ack[i]) span_req[i] = 1'b0;
  endtask

  task automatic test_reset();
    @(negedge clk);
    rst_n = 1'b0;
    span_req = '0;
    repeat (2) @(negedge clk);
    compared++;
    if ({span_ack, rom_row, rom_col, pix_valid, pix_id, pix_col, pix_color,
         pix_opaque, pix_last, busy, dbg_state} !== '0) begin
      mismatched++;
      $display("FAIL reset_outputs: got ack=%b row=%0d col=%0d pv=%b busy=%b st=%b, required all 0",
               span_ack, rom_row, rom_col, pix_valid, busy, dbg_state);
    end
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_single();
    logic [11:0] exp_color;
    @(negedge clk);
    set_req(0, 120, 100, 5);
    for (int c = 1; c <= 9; c++) begin
      @(negedge clk);
      compared++;
      if (span_ack !== ((c == 1) ? 4'b0001 : 4'b0000)) begin
        mismatched++; $display("FAIL single_ack c=%0d got %b", c, span_ack);
      end
      if (c <= 5) begin
        compared++;
        if (rom_col !== COL_W'(99 + c) || rom_row !== 8'd120) begin
          mismatched++; $display("FAIL single_rom c=%0d got row=%0d col=%0d exp 120/%0d", c, rom_row, rom_col, 99 + c);
        end
      end
      compared++;
      if (pix_valid !== (c >= 3 && c <= 7)) begin
        mismatched++; $display("FAIL single_valid c=%0d got %b", c, pix_valid);
      end
      if (c >= 3 && c <= 7) begin
        exp_color = {4'h8, 8'(97 + c)};
        compared++;
        if (pix_col !== COL_W'(97 + c) || pix_id !== 2'd0 || pix_last !== (c == 7) ||
            pix_color !== exp_color || pix_opaque !== 1'b1) begin
          mismatched++;
          $display("FAIL single_pix c=%0d got col=%0d id=%0d last=%b color=%h op=%b exp col=%0d last=%b color=%h",
                   c, pix_col, pix_id, pix_last, pix_color, pix_opaque, 97 + c, (c == 7), exp_color);
        end
      end
      compared++;
      if (busy !== (c <= 7)) begin
        mismatched++; $display("FAIL single_busy c=%0d got %b exp %b", c, busy, (c <= 7));
      end
      drop_acked();
    end
  endtask

  task automatic test_contention();
    int ack_cyc [6] = '{1, 5, 9, 13, 17, 21};
    int ack_id  [6] = '{0, 1, 2, 3, 0, 3};
    logic [3:0] exp_ack;
    logic exp_v, exp_last;
    int eid, ecol, k;
    @(negedge clk);
    for (int i = 0; i < N_REQ; i++) set_req(i, i + 1, 200 + 16 * i, 3);
    for (int c = 1; c <= 27; c++) begin
      @(negedge clk);
      exp_ack = '0; exp_v = 1'b0; exp_last = 1'b0; eid = 0; ecol = 0;
      for (int s = 0; s < 6; s++) begin
        if (c == ack_cyc[s]) exp_ack[ack_id[s]] = 1'b1;
        k = c - ack_cyc[s] - 2;
        if (k >= 0 && k <= 2) begin
          exp_v = 1'b1; eid = ack_id[s]; ecol = 200 + 16 * eid + k; exp_last = (k == 2);
        end
      end
      compared++;
      if (span_ack !== exp_ack) begin
        mismatched++; $display("FAIL cont_ack c=%0d got %b exp %b", c, span_ack, exp_ack);
      end
      compared++;
      if (pix_valid !== exp_v) begin
        mismatched++; $display("FAIL cont_valid c=%0d got %b exp %b", c, pix_valid, exp_v);
      end
      if (exp_v) begin
        compared++;
        if (pix_id !== ID_W'(eid) || pix_col !== COL_W'(ecol) || pix_last !== exp_last) begin
          mismatched++;
          $display("FAIL cont_pix c=%0d got id=%0d col=%0d last=%b exp id=%0d col=%0d last=%b",
                   c, pix_id, pix_col, pix_last, eid, ecol, exp_last);
        end
      end
      if (c >= 26) begin
        compared++;
        if (busy !== 1'b0) begin
          mismatched++; $display("FAIL cont_busy c=%0d got %b exp 0", c, busy);
        end
      end
      drop_acked();
      if (c == 14) begin
        span_req[0] = 1'b1;
        span_req[3] = 1'b1;
      end
    end
  endtask

  task automatic test_clip();
    @(negedge clk);
    set_req(1, 5, 580, 10);
    for (int c = 1; c <= 8; c++) begin
      @(negedge clk);
      compared++;
      if (span_ack !== ((c == 1) ? 4'b0010 : 4'b0000)) begin
        mismatched++; $display("FAIL clip_ack c=%0d got %b", c, span_ack);
      end
      compared++;
      if (rom_col !== COL_W'((c <= 4) ? 579 + c : 583)) begin
        mismatched++; $display("FAIL clip_rom c=%0d got %0d", c, rom_col);
      end
      compared++;
      if (pix_valid !== (c >= 3 && c <= 6)) begin
        mismatched++; $display("FAIL clip_valid c=%0d got %b", c, pix_valid);
      end
      if (c >= 3 && c <= 6) begin
        compared++;
        if (pix_col !== COL_W'(577 + c) || pix_last !== (c == 6) || pix_id !== 2'd1) begin
          mismatched++; $display("FAIL clip_pix c=%0d got col=%0d last=%b id=%0d exp col=%0d last=%b",
                                 c, pix_col, pix_last, pix_id, 577 + c, (c == 6));
        end
      end
      drop_acked();
    end
  endtask

  task automatic test_null(input string name, input int i, input int col, input int len,
                           input int hold_row, input int hold_col);
    logic [3:0] ack_bit;
    ack_bit = 4'b0001 << i;
    @(negedge clk);
    set_req(i, 77, col, len);
    for (int c = 1; c <= 6; c++) begin
      @(negedge clk);
      compared++;
      if (span_ack !== ((c == 1) ? ack_bit : 4'b0000)) begin
        mismatched++; $display("FAIL %s_ack c=%0d got %b exp %b", name, c, span_ack, ack_bit);
      end
      compared++;
      if (rom_row !== ROW_W'(hold_row) || rom_col !== COL_W'(hold_col)) begin
        mismatched++; $display("FAIL %s_rom c=%0d got %0d/%0d exp %0d/%0d", name, c, rom_row, rom_col, hold_row, hold_col);
      end
      compared++;
      if (pix_valid !== (c == 3) || dbg_state !== (c == 1) || busy !== (c <= 3)) begin
        mismatched++; $display("FAIL %s_flow c=%0d got pv=%b st=%b busy=%b", name, c, pix_valid, dbg_state, busy);
      end
      if (c == 3) begin
        compared++;
        if (pix_last !== 1'b1 || pix_opaque !== 1'b0 || pix_id !== ID_W'(i)) begin
          mismatched++; $display("FAIL %s_pix got last=%b op=%b id=%0d exp 1/0/%0d", name, pix_last, pix_opaque, pix_id, i);
        end
      end
      drop_acked();
    end
  endtask

  task automatic test_transparency();
    logic exp_op;
    rom_mode = 1;
    @(negedge clk);
    set_req(0, 7, 8, 7);
    for (int c = 1; c <= 10; c++) begin
      @(negedge clk);
      compared++;
      if (pix_valid !== (c >= 3 && c <= 9)) begin
        mismatched++; $display("FAIL transp_valid c=%0d got %b", c, pix_valid);
      end
      if (c >= 3 && c <= 9) begin
        exp_op = (c + 5 >= 10) && (c + 5 <= 12);
        compared++;
        if (pix_col !== COL_W'(c + 5) || pix_opaque !== exp_op ||
            pix_color !== (exp_op ? 12'hF23 : 12'hFFF)) begin
          mismatched++; $display("FAIL transp_pix c=%0d got col=%0d op=%b color=%h exp col=%0d op=%b",
                                 c, pix_col, pix_opaque, pix_color, c + 5, exp_op);
        end
      end
      drop_acked();
    end
    rom_mode = 0;
  endtask

  task automatic test_reset_mid_burst();
    @(negedge clk);
    set_req(1, 9, 300, 8);
    for (int c = 1; c <= 4; c++) begin
      @(negedge clk);
      drop_acked();
    end
    compared++;
    if (rom_col !== 10'd303) begin
      mismatched++; $display("FAIL midrst_pre rom_col got %0d exp 303", rom_col);
    end
    rst_n = 1'b0;
    @(negedge clk);
    compared++;
    if ({span_ack, rom_row, rom_col, pix_valid, pix_id, pix_col, pix_color,
         pix_opaque, pix_last, busy, dbg_state} !== '0) begin
      mismatched++;
      $display("FAIL midrst_outputs got ack=%b col=%0d pv=%b last=%b busy=%b st=%b, required all 0",
               span_ack, rom_col, pix_valid, pix_last, busy, dbg_state);
    end
    rst_n = 1'b1;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      compared++;
      if (pix_valid !== 1'b0 || span_ack !== 4'b0000 || busy !== 1'b0) begin
        mismatched++; $display("FAIL midrst_quiet c=%0d got pv=%b ack=%b busy=%b", c, pix_valid, span_ack, busy);
      end
    end
    set_req(1, 9, 40, 1);
    set_req(2, 9, 60, 1);
    for (int d = 1; d <= 8; d++) begin
      @(negedge clk);
      compared++;
      if (span_ack !== ((d == 1) ? 4'b0010 : (d == 3) ? 4'b0100 : 4'b0000)) begin
        mismatched++; $display("FAIL midrst_ptr d=%0d got %b", d, span_ack);
      end
      drop_acked();
    end
  endtask

  // Watchdog
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  // Sequence and final report
  initial begin
    test_reset();
    test_single();
    test_reset();
    test_contention();
    test_clip();
    test_null("null_len", 2, 50, 0, 5, 583);
    test_null("null_col", 3, 600, 5, 5, 583);
    test_transparency();
    test_reset_mid_burst();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
